// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the program counter, drives a 1-cycle-latency
// instruction memory and presents one instruction per cycle to the decoder.
// Handles the start/done run handshake, taken-branch redirects and stalls.
// A NOP is presented whenever no valid instruction is on the bus.
module instr_fetch #(
  parameter int              PC_W       = 10,
  parameter logic [PC_W-1:0] START_ADDR = '0,
  parameter logic [8:0]      NOP_INSTR  = 9'h1F4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            done_i,
  input  logic            branch_taken,
  input  logic [PC_W-1:0] branch_target,
  input  logic            stall,
  output logic [PC_W-1:0] imem_addr,
  input  logic [8:0]      imem_rdata,
  output logic [8:0]      instr,
  output logic            instr_valid,
  output logic [PC_W-1:0] pc,
  output logic            running,
  output logic            halted,
  output logic [15:0]     cycle_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [PC_W-1:0] fetch_pc;
  logic            start_q;
  logic            start_rise;

  // PC arithmetic wraps modulo 2^PC_W with no error indication.
  function automatic logic [PC_W-1:0] pc_inc(input logic [PC_W-1:0] a);
    return a + PC_W'(1);
  endfunction

  // Run-cycle counter saturates instead of wrapping.
  function automatic logic [15:0] cnt_sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign start_rise = start & ~start_q;
  assign instr      = instr_valid ? imem_rdata : NOP_INSTR;
  // While stalled on a valid instruction, re-read it so instr stays stable.
  assign imem_addr  = (state == RUN && stall && instr_valid) ? pc : fetch_pc;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic: start edge enters RUN, done on a valid, unstalled instruction halts.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, HALT: if (start_rise) state_nxt = RUN;
      RUN:        if (instr_valid && !stall && done_i) state_nxt = HALT;
      default:    state_nxt = IDLE;
    endcase
  end

  // Status outputs decoded from the state.
  always_comb begin
    running = (state == RUN);
    halted  = (state == HALT);
  end

  // Fetch datapath: PC, fetch pointer, valid flag, start edge sampler and run counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc    <= START_ADDR;
      pc          <= START_ADDR;
      instr_valid <= 1'b0;
      start_q     <= 1'b0;
      cycle_count <= 16'd0;
    end else begin
      start_q <= start;
      if (state == RUN) begin
        cycle_count <= cnt_sat_inc(cycle_count);
        if (instr_valid && stall) begin
          // Hold everything; done and redirect wait until the stall clears.
        end else if (instr_valid && done_i) begin
          instr_valid <= 1'b0;
          fetch_pc    <= START_ADDR;
        end else if (instr_valid && branch_taken) begin
          // One bubble: the target is read now and shows up next cycle.
          fetch_pc    <= branch_target;
          instr_valid <= 1'b0;
        end else begin
          pc          <= fetch_pc;
          fetch_pc    <= pc_inc(fetch_pc);
          instr_valid <= 1'b1;
        end
      end else if (start_rise) begin
        // START_ADDR is on imem_addr this cycle, so its data lands with pc.
        pc          <= START_ADDR;
        fetch_pc    <= pc_inc(START_ADDR);
        instr_valid <= 1'b1;
        cycle_count <= 16'd0;
      end else begin
        instr_valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Fetch stage directly upstream of the instruction decoder; supplies one 9-bit instruction per cycle on `instr`.
- Owns the program counter and drives a synchronous-read instruction memory (1-cycle read latency).
- Handles the start/done run handshake, taken-branch/jump redirects from the execute side, and pipeline stalls.
- Whenever no valid instruction is present, it presents the NOP encoding so the decoder stays inert.

Parameters:
PC_W, 10, width of program counter and instruction memory address
START_ADDR, 0, address of first instruction after each start
NOP_INSTR, 9'h1F4, encoding driven on instr when instr_valid=0 (decodes as noop)

Ports:
clk  in  1  system clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  run request; rising edge (0->1 between consecutive clk samples) starts execution
done_i  in  1  decoder done flag for the instruction currently on instr
branch_taken  in  1  redirect request for the instruction currently on instr
branch_target  in  PC_W  redirect destination address
stall  in  1  hold current instruction (downstream busy)
imem_addr  out  PC_W  instruction memory read address
imem_rdata  in  9  instruction memory data, valid 1 cycle after imem_addr
instr  out  9  instruction to decoder
instr_valid  out  1  instr is a real instruction
pc  out  PC_W  address of instruction on instr
running  out  1  state==RUN
halted  out  1  state==HALT
cycle_count  out  16  clocks spent in RUN since last start, saturating

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, fetch_pc=START_ADDR, pc=START_ADDR, instr_valid=0, start_q=0, cycle_count=0.
  - Outputs follow the registers immediately: running=0, halted=0.
- Combinational outputs:
  - instr = instr_valid ? imem_rdata : NOP_INSTR.
  - imem_addr = (state==RUN && stall && instr_valid) ? pc : fetch_pc.
  - start_q registers start every cycle; start_rise = start & ~start_q.
- IDLE / HALT, start_rise:
  - ->RUN; pc<=START_ADDR, fetch_pc<=START_ADDR+1, instr_valid<=1, cycle_count<=0.
  - imem_addr is START_ADDR during the start_rise cycle, so the first instruction appears the next cycle.
- IDLE / HALT, no start_rise: hold all state, instr_valid=0.
- RUN: cycle_count increments every cycle, saturating at 16'hFFFF. Each cycle takes the first matching case in this priority order:
  1. instr_valid && stall: hold pc, fetch_pc, instr_valid. imem_addr=pc re-reads the held instruction, so instr is stable for the whole stall. done_i and branch_taken are ignored.
  2. instr_valid && done_i: ->HALT; instr_valid<=0, pc held (last executed address), fetch_pc<=START_ADDR. done has priority over branch_taken.
  3. instr_valid && branch_taken: fetch_pc<=branch_target, instr_valid<=0 (one bubble). Next cycle pc<=branch_target, fetch_pc<=branch_target+1, instr_valid<=1. Taken-branch penalty is exactly 1 cycle.
  4. Otherwise: pc<=fetch_pc, fetch_pc<=fetch_pc+1, instr_valid<=1.
- Bubble cycles (instr_valid=0 in RUN): stall, done_i and branch_taken are ignored; the fetch advances per case 4.
- Address arithmetic:
  - All PC arithmetic is modulo 2^PC_W.
  - fetch_pc = 2^PC_W-1 wraps to 0 with no error flag.
  - branch_target is used as-is; no range check.
- start_rise while in RUN: ignored, no restart.
- Reset mid-run: execution aborts immediately to reset values. A new start_rise is required after rst_n deasserts; a start held high through reset counts as a rise only if start_q is sampled 0 first.
- Throughput: 1 instruction/cycle absent stall and branch.
- Start-to-first-instruction latency: instr_valid rises 1 cycle after start_rise.

Test Plan:
1. Reset, then start 0->1 with imem[0..3]=9'h010,9'h021,9'h032,9'h043 -> next cycles instr=010,021,032,043 with pc=0,1,2,3, instr_valid=1 continuously; before start instr=1F4, instr_valid=0.
2. branch_taken=1, target=10'h040 while pc=2 -> following cycle instr_valid=0, instr=1F4; next cycle pc=040, instr=imem[040]; then pc=041.
3. stall=1 for 3 cycles at pc=5, with branch_taken=1 and done_i=1 also asserted -> instr and pc=5 held all 3 cycles, no redirect, no halt; after release pc=6.
4. done_i=1 at pc=7 -> next cycle halted=1, running=0, instr_valid=0, pc=7. start held high gives no restart; start 0->1 restarts at pc=0 with cycle_count=0.
5. PC_W=4, straight-line code through address 15 -> pc sequence 14,15,0,1.
6. rst_n pulsed low mid-RUN at pc=9 -> asynchronously instr_valid=0, running=0, pc=0, cycle_count=0; remains IDLE until next start rise.
